rat_ckpt: RTL
=============

# rat_ckpt

Parametrised rename stage: maps architectural integer registers onto physical registers for a group of up to RENAME_WIDTH micro-ops per cycle. It owns the mapping table, the physical free list and a ring of branch checkpoints, and sits between decode and dispatch in the frontend. Compared with the previous rename block it adds:
- configurable width and depth;
- intra-group dependency bypass;
- valid/ready backpressure on both sides;
- single-cycle recovery of both the map and the free list from any live checkpoint.

## Interface
- ARF_SIZE, 32: architectural registers; index 0 is hard-wired zero.
- PRF_SIZE, 64: physical registers; must be > ARF_SIZE + RENAME_WIDTH.
- RENAME_WIDTH, 2: slots per group.
- COMMIT_WIDTH, 2: retire slots per cycle.
- CP_DEPTH, 4: checkpoint ring entries; power of two.
- Derived: AW = $clog2(ARF_SIZE), PW = $clog2(PRF_SIZE), CW = $clog2(CP_DEPTH).

Ports:
- clock  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  group offered.
- in_ready  out  1  group accepted when in_valid & in_ready.
- in_slot_valid / in_rd_valid / in_branch  in  RENAME_WIDTH  per-slot flags.
- in_rs1 / in_rs2 / in_rd  in  RENAME_WIDTH x AW  architectural indices.
- out_valid  out  1  renamed group held in the output register.
- out_ready  in  1  consumer accepts.
- out_slot_valid  out  RENAME_WIDTH  copy of in_slot_valid.
- out_prs1 / out_prs2 / out_prd / out_prev_prd  out  RENAME_WIDTH x PW  physical indices.
- out_prev_prd_valid  out  RENAME_WIDTH  out_prev_prd is meaningful.
- out_cp_valid  out  RENAME_WIDTH  slot took a checkpoint.
- out_cp_index  out  RENAME_WIDTH x CW  index of that checkpoint.
- retire_valid / retire_prev_valid / retire_branch  in  COMMIT_WIDTH  retire flags.
- retire_prev_prd  in  COMMIT_WIDTH x PW  physical register to free.
- recover  in  1  branch mispredict.
- recover_cp_index  in  CW  checkpoint to restore.
- free_count  out  PW+1  number of free physical registers.
- cp_count  out  CW+1  number of live checkpoints.

## Operation
- **Reset** (async, reset_n low):
  - map[i] = i for all i.
  - PRF 0..ARF_SIZE-1 busy; the rest free.
  - cp_head = 0, cp_count = 0.
  - out_valid = 0; all other outputs 0.
  - free_count = PRF_SIZE - ARF_SIZE.
- **Accept:** in_ready = (~out_valid | out_ready) & ~recover & free_count >= RENAME_WIDTH & cp_count <= CP_DEPTH - RENAME_WIDTH. It never depends on the in_* data.
- **Renaming**, per valid slot i in order 0..W-1:
  - A slot writes when in_rd_valid & in_rd != 0.
  - prs1/prs2: taken from the youngest earlier writing slot j<i with rd_j == rs; otherwise from map. Source 0 always yields 0.
  - A writing slot gets the k-th lowest-indexed free PRF, where k is its rank among writing slots. That PRF is cleared from the free list.
  - prev_prd is the pre-slot mapping, including bypass from earlier slots; prev_prd_valid = 1.
  - A non-writing slot drives prd = 0 and prev_prd_valid = 0.
  - Map updates after the group: the youngest writer wins for each rd.
- **Checkpoint:** a valid slot with in_branch allocates entry (cp_head + cp_count + rank) mod CP_DEPTH. It stores:
  - the map as it stands after that slot;
  - a zeroed alloc_since mask.
  
  Later slots' allocations in the same group, and all allocations in later cycles, are OR-ed into alloc_since of every live checkpoint.
- **Retire:**
  - Each retire_valid & retire_prev_valid sets retire_prev_prd free.
  - Each retire_valid & retire_branch pops the head: cp_head += 1, cp_count -= 1.
- **Recover** (checkpoint k, applied at the clock edge):
  - map <= snapshot[k].
  - free <= free | alloc_since[k] | this cycle's retire frees.
  - alloc_since[k] <= 0.
  - cp_count <= ((k - cp_head_next) mod CP_DEPTH) + 1, so k stays live and younger entries are discarded.
  - out_valid <= 0 and no group is accepted that cycle.
- **Upstream guarantees:**
  - k is live and is not popped in the same cycle.
  - Freed PRFs are busy and never 0.

## Timing
- Latency 1: an accepted group appears on out_* the next cycle.
- out_* stays stable while out_valid & ~out_ready.
- Free list, map and checkpoint updates commit on the accepting edge. Retire frees are visible to allocation from the next cycle; there is no same-cycle free-to-allocate bypass.
- free_count and cp_count are registered and reflect all updates of the previous edge.
- Simultaneous retire + accept + pop in one cycle is legal. Allocation reads pre-edge state.
- Checkpoint index arithmetic wraps modulo CP_DEPTH. cp_count saturates at neither end; over- and underflow are prevented by in_ready and the guarantees above.
- reset_n asserted mid-operation clears all state immediately. The first accept is possible on the first edge after deassertion.

## Test plan
- **Reset:** release reset_n, rename rs1=5, rs2=0, rd=3 in slot 0 -> prs1=5, prs2=0, prd=32, prev_prd=3, free_count 32→31.
- **Bypass:** group slot0 rd=7, slot1 rs1=7, rd=7 -> slot1 prs1=slot0 prd=32, prd=33, prev_prd=32; map[7]=33 afterwards.
- **Backpressure:** hold out_ready=0 for 3 cycles -> out_* unchanged, in_ready=0; release -> next group accepted on the same edge.
- **Recover:** branch in slot0 (checkpoint 0), then 2 groups allocate 4 PRFs, then recover k=0 -> free_count back to its pre-allocation value, map equals snapshot, cp_count=1, out_valid=0.
- **Wrap:** fill to cp_count=CP_DEPTH-1, retire 3 branches, allocate 3 more -> indices wrap 3,0,1; in_ready deasserts exactly when cp_count > CP_DEPTH-RENAME_WIDTH.
- **Free-list exhaustion:** rename until free_count=1 -> in_ready=0; retire one prev_prd -> free_count=2 next cycle, in_ready=1.

Source files
------------

// File: rtl/rat_ckpt.sv
// Rename stage: arch-to-phys map, physical free list and a ring of
// branch checkpoints with single-cycle recovery of map and free list.
module rat_ckpt #(
  parameter int ARF_SIZE     = 32,
  parameter int PRF_SIZE     = 64,
  parameter int RENAME_WIDTH = 2,
  parameter int COMMIT_WIDTH = 2,
  parameter int CP_DEPTH     = 4,
  localparam int AW = $clog2(ARF_SIZE),
  localparam int PW = $clog2(PRF_SIZE),
  localparam int CW = $clog2(CP_DEPTH),
  localparam int RW = RENAME_WIDTH,
  localparam int CM = COMMIT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RW-1:0]    in_slot_valid,
  input  logic [RW-1:0]    in_rd_valid,
  input  logic [RW-1:0]    in_branch,
  input  logic [RW*AW-1:0] in_rs1,
  input  logic [RW*AW-1:0] in_rs2,
  input  logic [RW*AW-1:0] in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RW-1:0]    out_slot_valid,
  output logic [RW*PW-1:0] out_prs1,
  output logic [RW*PW-1:0] out_prs2,
  output logic [RW*PW-1:0] out_prd,
  output logic [RW*PW-1:0] out_prev_prd,
  output logic [RW-1:0]    out_prev_prd_valid,
  output logic [RW-1:0]    out_cp_valid,
  output logic [RW*CW-1:0] out_cp_index,
  input  logic [CM-1:0]    retire_valid,
  input  logic [CM-1:0]    retire_prev_valid,
  input  logic [CM-1:0]    retire_branch,
  input  logic [CM*PW-1:0] retire_prev_prd,
  input  logic             recover,
  input  logic [CW-1:0]    recover_cp_index,
  output logic [PW:0]      free_count,
  output logic [CW:0]      cp_count
);

  function automatic logic [PW-1:0] first_free(
    input logic [PRF_SIZE-1:0] v
  );
    logic [PW-1:0] r;
    r = '0;
    for (int p = PRF_SIZE - 1; p >= 0; p--)
      if (v[p]) r = PW'(p);
    return r;
  endfunction

  function automatic logic [PW:0] count_ones(
    input logic [PRF_SIZE-1:0] v
  );
    logic [PW:0] n;
    n = '0;
    for (int p = 0; p < PRF_SIZE; p++)
      n = n + {{PW{1'b0}}, v[p]};
    return n;
  endfunction

  logic [PW-1:0]       map_q  [ARF_SIZE];
  logic [PW-1:0]       snap_q [CP_DEPTH][ARF_SIZE];
  logic [PRF_SIZE-1:0] alloc_q [CP_DEPTH];
  logic [PRF_SIZE-1:0] free_q;
  logic [CW-1:0]       head_q;

  logic [PW-1:0]       map_w  [ARF_SIZE];
  logic [PW-1:0]       snap_w [RW][ARF_SIZE];
  logic [PRF_SIZE-1:0] own_alloc   [RW];
  logic [PRF_SIZE-1:0] later_alloc [RW];
  logic [PRF_SIZE-1:0] avail;
  logic [PRF_SIZE-1:0] grp_alloc;
  logic [RW*PW-1:0]    prs1_w, prs2_w;
  logic [RW*PW-1:0]    prd_w, prev_w;
  logic [RW-1:0]       pv_w, cpv_w;
  logic [RW*CW-1:0]    cpi_w;
  logic [CW-1:0]       brank;
  logic [CW:0]         nbr;
  logic [AW-1:0]       rs1, rs2, rd;
  logic [PW-1:0]       pick;

  logic [PRF_SIZE-1:0] rfree;
  logic [PRF_SIZE-1:0] free_n;
  logic [CW:0]         pops;
  logic [CW:0]         cnt_n;
  logic [CW-1:0]       head_n;
  logic                accept;

  assign in_ready = (~out_valid | out_ready) & ~recover
                  & (free_count >= (PW+1)'(RW))
                  & (cp_count <= (CW+1)'(CP_DEPTH - RW));
  assign accept = in_valid & in_ready;

  // Slots walk a working copy of the map so later slots see earlier writers.
  always_comb begin
    map_w  = map_q;
    avail  = free_q;
    brank  = '0;
    nbr    = '0;
    prs1_w = '0;
    prs2_w = '0;
    prd_w  = '0;
    prev_w = '0;
    pv_w   = '0;
    cpv_w  = '0;
    cpi_w  = '0;
    rs1    = '0;
    rs2    = '0;
    rd     = '0;
    pick   = '0;
    for (int i = 0; i < RW; i++) begin
      own_alloc[i] = '0;
      rs1 = in_rs1[i*AW +: AW];
      rs2 = in_rs2[i*AW +: AW];
      rd  = in_rd[i*AW +: AW];
      if (in_slot_valid[i]) begin
        prs1_w[i*PW +: PW] = (rs1 == '0) ? '0 : map_w[rs1];
        prs2_w[i*PW +: PW] = (rs2 == '0) ? '0 : map_w[rs2];
        if (in_rd_valid[i] && rd != '0) begin
          pick = first_free(avail);
          prd_w[i*PW +: PW]  = pick;
          prev_w[i*PW +: PW] = map_w[rd];
          pv_w[i]            = 1'b1;
          own_alloc[i][pick] = 1'b1;
          avail[pick]        = 1'b0;
          map_w[rd]          = pick;
        end
        if (in_branch[i]) begin
          cpv_w[i] = 1'b1;
          cpi_w[i*CW +: CW] = head_q + cp_count[CW-1:0] + brank;
          brank = brank + CW'(1);
          nbr   = nbr + (CW+1)'(1);
        end
      end
      snap_w[i] = map_w;
    end
    grp_alloc = free_q & ~avail;
    for (int i = 0; i < RW; i++) begin
      later_alloc[i] = '0;
      for (int j = 0; j < RW; j++)
        if (j > i) later_alloc[i] = later_alloc[i] | own_alloc[j];
    end
  end

  always_comb begin
    rfree = '0;
    pops  = '0;
    for (int c = 0; c < CM; c++) begin
      if (retire_valid[c] && retire_prev_valid[c])
        rfree[retire_prev_prd[c*PW +: PW]] = 1'b1;
      if (retire_valid[c] && retire_branch[c])
        pops = pops + (CW+1)'(1);
    end
    head_n = head_q + pops[CW-1:0];
    free_n = free_q | rfree;
    if (recover) begin
      free_n = free_n | alloc_q[recover_cp_index];
      cnt_n  = {1'b0, recover_cp_index - head_n} + (CW+1)'(1);
    end else begin
      if (accept) free_n = free_n & ~grp_alloc;
      cnt_n = cp_count - pops + (accept ? nbr : '0);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < PRF_SIZE; p++)
        free_q[p] <= (p >= ARF_SIZE);
      free_count <= (PW+1)'(PRF_SIZE - ARF_SIZE);
      head_q     <= '0;
      cp_count   <= '0;
    end else begin
      free_q     <= free_n;
      free_count <= count_ones(free_n);
      head_q     <= head_n;
      cp_count   <= cnt_n;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int a = 0; a < ARF_SIZE; a++)
        map_q[a] <= PW'(a);
    end else if (recover) begin
      map_q <= snap_q[recover_cp_index];
    end else if (accept) begin
      map_q <= map_w;
    end
  end

  // Every group allocation lands in all masks; a fresh entry then overrides.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int e = 0; e < CP_DEPTH; e++) begin
        alloc_q[e] <= '0;
        for (int a = 0; a < ARF_SIZE; a++)
          snap_q[e][a] <= '0;
      end
    end else if (recover) begin
      alloc_q[recover_cp_index] <= '0;
    end else if (accept) begin
      for (int e = 0; e < CP_DEPTH; e++)
        alloc_q[e] <= alloc_q[e] | grp_alloc;
      for (int i = 0; i < RW; i++)
        if (cpv_w[i]) begin
          snap_q[cpi_w[i*CW +: CW]]  <= snap_w[i];
          alloc_q[cpi_w[i*CW +: CW]] <= later_alloc[i];
        end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid          <= 1'b0;
      out_slot_valid     <= '0;
      out_prs1           <= '0;
      out_prs2           <= '0;
      out_prd            <= '0;
      out_prev_prd       <= '0;
      out_prev_prd_valid <= '0;
      out_cp_valid       <= '0;
      out_cp_index       <= '0;
    end else begin
      if (recover)        out_valid <= 1'b0;
      else if (accept)    out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      if (accept) begin
        out_slot_valid     <= in_slot_valid;
        out_prs1           <= prs1_w;
        out_prs2           <= prs2_w;
        out_prd            <= prd_w;
        out_prev_prd       <= prev_w;
        out_prev_prd_valid <= pv_w;
        out_cp_valid       <= cpv_w;
        out_cp_index       <= cpi_w;
      end
    end
  end

endmodule
